// File: rtl/sar_logic_param.sv
// Parametrised SAR ADC controller: sequences sampling, comparator strobes and the
// CDAC binary search, then publishes the result with a one-cycle end-of-conversion.
module sar_logic_param #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int CMP_WAIT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnvst,
  input  logic             cont,
  input  logic             abort,
  input  logic             cmp_out,
  output logic             s_clk,
  output logic             cmp_clk,
  output logic [WIDTH-1:0] dac_ctrl,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             eoc
);

  localparam int BW = $clog2(WIDTH);
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  localparam logic [WIDTH-1:0] MID    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [BW-1:0]    B_TOP  = BW'(WIDTH - 1);
  localparam logic [SW-1:0]    S_LOAD = SW'(SAMPLE_CYCLES - 1);
  localparam logic [3:0]       W_LOAD = 4'((CMP_WAIT > 0) ? (CMP_WAIT - 1) : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    COMPARE = 3'd2,
    WAIT    = 3'd3,
    DECIDE  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] trial_r;
  logic [WIDTH-1:0] dout_r;
  logic [BW-1:0]    b_r;
  logic [SW-1:0]    scnt_r;
  logic [3:0]       wcnt_r;
  logic             s_clk_r;
  logic             cmp_clk_r;
  logic             busy_r;
  logic             eoc_r;

  // Resolve the trial bit under test with the comparator verdict and arm the next one.
  function automatic logic [WIDTH-1:0] decide_code(
    input logic [WIDTH-1:0] code,
    input logic [BW-1:0]    bit_idx,
    input logic             cmp
  );
    logic [WIDTH-1:0] res;
    res = code;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == int'(bit_idx)) begin
        res[i] = cmp;
      end else if ((bit_idx != {BW{1'b0}}) && (i == int'(bit_idx) - 1)) begin
        res[i] = 1'b1;
      end else begin
        res[i] = code[i];
      end
    end
    return res;
  endfunction

  assign s_clk    = s_clk_r;
  assign cmp_clk  = cmp_clk_r;
  assign busy     = busy_r;
  assign eoc      = eoc_r;
  assign dac_ctrl = trial_r;
  assign dout     = dout_r;

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cnvst) state_s = SAMPLE;
          else       state_s = IDLE;
        end
        SAMPLE: begin
          if (scnt_r == {SW{1'b0}}) state_s = COMPARE;
          else                      state_s = SAMPLE;
        end
        COMPARE: begin
          if (CMP_WAIT == 0) state_s = DECIDE;
          else               state_s = WAIT;
        end
        WAIT: begin
          if (wcnt_r == 4'd0) state_s = DECIDE;
          else                state_s = WAIT;
        end
        DECIDE: begin
          if (b_r == {BW{1'b0}}) state_s = DONE;
          else                   state_s = COMPARE;
        end
        DONE: begin
          if (cont) state_s = SAMPLE;
          else      state_s = IDLE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, counters, trial/result registers and registered Moore output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      trial_r   <= MID;
      dout_r    <= {WIDTH{1'b0}};
      b_r       <= B_TOP;
      scnt_r    <= {SW{1'b0}};
      wcnt_r    <= 4'd0;
      s_clk_r   <= 1'b0;
      cmp_clk_r <= 1'b0;
      busy_r    <= 1'b0;
      eoc_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      s_clk_r   <= (state_s == SAMPLE);
      cmp_clk_r <= (state_s == COMPARE);
      busy_r    <= (state_s != IDLE);
      eoc_r     <= (state_s == DONE);
      if (abort) begin
        trial_r <= MID;
        b_r     <= B_TOP;
      end else begin
        case (state_r)
          IDLE: begin
            trial_r <= MID;
            if (cnvst) begin
              scnt_r <= S_LOAD;
              b_r    <= B_TOP;
            end
          end
          SAMPLE: begin
            if (scnt_r != {SW{1'b0}}) scnt_r <= scnt_r - SW'(1);
          end
          COMPARE: begin
            if (CMP_WAIT != 0) wcnt_r <= W_LOAD;
          end
          WAIT: begin
            if (wcnt_r != 4'd0) wcnt_r <= wcnt_r - 4'd1;
          end
          DECIDE: begin
            trial_r <= decide_code(trial_r, b_r, cmp_out);
            if (b_r != {BW{1'b0}}) begin
              b_r <= b_r - BW'(1);
            end else begin
              dout_r <= decide_code(trial_r, b_r, cmp_out);
            end
          end
          DONE: begin
            trial_r <= MID;
            if (cont) begin
              b_r    <= B_TOP;
              scnt_r <= S_LOAD;
            end
          end
          default: begin
            trial_r <= MID;
            b_r     <= B_TOP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_logic_param.sv
// Self-checking bench for sar_logic_param: default 8-bit instance plus a
// WIDTH=12/SAMPLE_CYCLES=4/CMP_WAIT=2 instance, ideal comparator model (VIN >= DAC).
module tb_sar_logic_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cnvst, cont, abort, cmp_out;
  logic [7:0] vin;
  logic       s_clk, cmp_clk, busy, eoc;
  logic [7:0] dac_ctrl, dout;

  logic        cnvst12, cont12, abort12, cmp12;
  logic [11:0] vin12;
  logic        s_clk12, cmp_clk12, busy12, eoc12;
  logic [11:0] dac12, dout12;

  assign cmp_out = (vin >= dac_ctrl);
  assign cmp12   = (vin12 >= dac12);

  sar_logic_param dut (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont), .abort(abort), .cmp_out(cmp_out),
    .s_clk(s_clk), .cmp_clk(cmp_clk), .dac_ctrl(dac_ctrl), .busy(busy), .dout(dout), .eoc(eoc)
  );

  sar_logic_param #(.WIDTH(12), .SAMPLE_CYCLES(4), .CMP_WAIT(2)) dut12 (
    .clk(clk), .rst(rst), .cnvst(cnvst12), .cont(cont12), .abort(abort12), .cmp_out(cmp12),
    .s_clk(s_clk12), .cmp_clk(cmp_clk12), .dac_ctrl(dac12), .busy(busy12), .dout(dout12),
    .eoc(eoc12)
  );

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp_dout;
  } vec_t;

  int ncomp = 0;
  int nfail = 0;
  int cyc = 0;
  int s_cnt = 0, cmp_cnt = 0, gap_bad = 0, last_cmp = -1, eoc_cyc = 0;
  int s12_cnt = 0, cmp12_cnt = 0, gap12_bad = 0, last_cmp12 = -1, eoc12_cyc = 0;
  logic [7:0]  first_dac = 8'h00;
  logic [11:0] first_dac12 = 12'h000;
  logic [7:0]  exp_q[$];
  logic [11:0] exp12_q[$];

  task automatic check(input string name, input int act, input int exp);
    ncomp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: step to the falling edge, then observe both DUTs and score eoc results.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (s_clk) begin s_cnt++; last_cmp = -1; end
    if (cmp_clk) begin
      if (last_cmp < 0) first_dac = dac_ctrl;
      else if (cyc - last_cmp != 2) gap_bad++;
      last_cmp = cyc;
      cmp_cnt++;
    end
    if (eoc) begin
      eoc_cyc = cyc;
      if (exp_q.size() == 0) check("eoc_unexpected", int'(eoc), 0);
      else check("dout", int'(dout), int'(exp_q.pop_front()));
    end
    if (s_clk12) begin s12_cnt++; last_cmp12 = -1; end
    if (cmp_clk12) begin
      if (last_cmp12 < 0) first_dac12 = dac12;
      else if (cyc - last_cmp12 != 4) gap12_bad++;
      last_cmp12 = cyc;
      cmp12_cnt++;
    end
    if (eoc12) begin
      eoc12_cyc = cyc;
      if (exp12_q.size() == 0) check("eoc12_unexpected", int'(eoc12), 0);
      else check("dout12", int'(dout12), int'(exp12_q.pop_front()));
    end
  endtask

  task automatic wait_eoc(output int seen);
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick();
      if (eoc) seen = 1;
    end
  endtask

  task automatic wait_eoc12(output int seen);
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      tick();
      if (eoc12) seen = 1;
    end
  endtask

  task automatic run8(input logic [7:0] v, input logic [7:0] expd);
    int s0, c0, g0, st, seen;
    vin = v;
    exp_q.push_back(expd);
    s0 = s_cnt; c0 = cmp_cnt; g0 = gap_bad; st = cyc;
    cnvst = 1'b1;
    tick();
    cnvst = 1'b0;
    wait_eoc(seen);
    check("eoc_seen", seen, 1);
    check("latency", eoc_cyc - st - 1, 18);
    check("s_clk_cycles", s_cnt - s0, 2);
    check("cmp_pulses", cmp_cnt - c0, 8);
    check("cmp_gap", gap_bad - g0, 0);
    check("first_trial", int'(first_dac), 8'h80);
    tick();
    check("busy_after", int'(busy), 0);
  endtask

  task automatic run12(input logic [11:0] v);
    int s0, c0, g0, st, seen;
    vin12 = v;
    exp12_q.push_back(v);
    s0 = s12_cnt; c0 = cmp12_cnt; g0 = gap12_bad; st = cyc;
    cnvst12 = 1'b1;
    tick();
    cnvst12 = 1'b0;
    wait_eoc12(seen);
    check("eoc12_seen", seen, 1);
    check("latency12", eoc12_cyc - st - 1, 52);
    check("s_clk12_cycles", s12_cnt - s0, 4);
    check("cmp12_pulses", cmp12_cnt - c0, 12);
    check("cmp12_gap", gap12_bad - g0, 0);
    check("first_trial12", int'(first_dac12), 12'h800);
    tick();
    check("busy12_after", int'(busy12), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int seen, e1, e2, busy_low, c0;
    vecs[0] = '{vin: 8'hA5, exp_dout: 8'hA5};
    vecs[1] = '{vin: 8'h00, exp_dout: 8'h00};
    vecs[2] = '{vin: 8'hFF, exp_dout: 8'hFF};
    vecs[3] = '{vin: 8'h80, exp_dout: 8'h80};
    vecs[4] = '{vin: 8'h7F, exp_dout: 8'h7F};
    vecs[5] = '{vin: 8'h01, exp_dout: 8'h01};

    rst = 1'b1; cnvst = 1'b0; cont = 1'b0; abort = 1'b0; vin = 8'h00;
    cnvst12 = 1'b0; cont12 = 1'b0; abort12 = 1'b0; vin12 = 12'h000;
    #12;
    check("rst_dac", int'(dac_ctrl), 8'h80);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_eoc", int'(eoc), 0);
    check("rst_s_clk", int'(s_clk), 0);
    check("rst_cmp_clk", int'(cmp_clk), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run8(vecs[i].vin, vecs[i].exp_dout);

    run12(12'h5A3);

    // Continuous mode: back-to-back conversions with VIN changing in between.
    cont = 1'b1; vin = 8'h10;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hE7);
    cnvst = 1'b1;
    tick();
    cnvst = 1'b0;
    wait_eoc(seen);
    check("cont_eoc1_seen", seen, 1);
    e1 = eoc_cyc;
    vin = 8'hE7;
    busy_low = 0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick();
      if (i == 0) cont = 1'b0;
      if (!busy) busy_low++;
      if (eoc) seen = 1;
    end
    e2 = eoc_cyc;
    check("cont_eoc2_seen", seen, 1);
    check("cont_period", e2 - e1, 19);
    check("cont_busy_drop", busy_low, 0);
    tick();
    check("cont_busy_after", int'(busy), 0);

    // Abort during the fourth DECIDE.
    vin = 8'h3C;
    c0 = cmp_cnt;
    cnvst = 1'b1;
    tick();
    cnvst = 1'b0;
    for (int i = 0; i < 50 && (cmp_cnt - c0) < 4; i++) tick();
    check("abort_reach_cmp4", cmp_cnt - c0, 4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_dac", int'(dac_ctrl), 8'h80);
    check("abort_eoc", int'(eoc), 0);
    check("abort_dout_kept", int'(dout), 8'hE7);
    repeat (25) tick();
    check("abort_dout_later", int'(dout), 8'hE7);
    run8(8'h3C, 8'h3C);

    // abort and cnvst together in IDLE must not start a conversion.
    cnvst = 1'b1; abort = 1'b1;
    tick();
    cnvst = 1'b0; abort = 1'b0;
    check("abort_cnvst_idle", int'(busy), 0);
    tick();

    // Async reset mid-WAIT on the 12-bit instance; cnvst held across reset.
    vin12 = 12'h3C7;
    cnvst12 = 1'b1;
    tick();
    cnvst12 = 1'b0;
    for (int i = 0; i < 50 && !cmp_clk12; i++) tick();
    check("reach_cmp12", int'(cmp_clk12), 1);
    tick();
    #2 rst = 1'b1;
    cnvst12 = 1'b1;
    #1;
    check("arst_s_clk12", int'(s_clk12), 0);
    check("arst_cmp_clk12", int'(cmp_clk12), 0);
    check("arst_busy12", int'(busy12), 0);
    check("arst_eoc12", int'(eoc12), 0);
    check("arst_dout12", int'(dout12), 0);
    check("arst_dac12", int'(dac12), 12'h800);
    check("arst_dout8", int'(dout), 0);
    tick();
    check("rst_cnvst_ignored", int'(busy12), 0);
    rst = 1'b0;
    tick();
    check("post_rst_accept", int'(busy12), 1);
    cnvst12 = 1'b0;
    exp12_q.push_back(12'h3C7);
    wait_eoc12(seen);
    check("post_rst_eoc12_seen", seen, 1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
